pos_add_seq: RTL and testbench
==============================

# pos_add_seq

Multi-limb sequential adder controller for the Karatsuba datapath. It adds two wide positive integers by time-sharing one LIMB_BITS-wide pos_add slice over N_LIMBS cycles, least significant limb first, with the inter-limb carry held in a register. It trades latency for area on the wide partial-product recombination adds. Control is a start/busy/done handshake.

## Interface

Parameters:
- LIMB_BITS, default 4: width of the shared adder slice.
- N_LIMBS, default 4: number of limbs. Operand width is W = N_LIMBS*LIMB_BITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-high.
- start  input  1  request a new addition. Sampled only in IDLE.
- a  input  W  left operand. Captured on the accepting edge.
- b  input  W  right operand. Captured on the accepting edge.
- busy  output  1  high while limbs are being processed (RUN).
- done  output  1  one-cycle pulse; c is valid and updated.
- c  output  W+1  sum a+b. Holds its value until the next done.

## Operation

- Datapath, one limb per cycle:
  - slice 1 is pos_add of width LIMB_BITS. It adds a_limb[i] and b_limb[i] and gives s1 (LIMB_BITS+1 bits).
  - slice 2 is pos_add of width LIMB_BITS+1. It adds s1 and the zero-extended carry register and gives s2 (LIMB_BITS+2 bits).
  - s2[LIMB_BITS+1] is always 0.
  - limb result = s2[LIMB_BITS-1:0]. Next carry = s2[LIMB_BITS].
- Operand registers are shift registers, shifted right by LIMB_BITS per RUN cycle. Limb 0 is always at the low end.
- Result accumulator:
  - each limb result is shifted in from the top.
  - after N_LIMBS limbs, the accumulator holds bits W-1:0, and the final carry is bit W.
- States and transitions:
  - IDLE -> RUN on start=1. Captures a and b. Clears the carry, limb index and accumulator.
  - RUN: processes limb idx, then idx++. When idx = N_LIMBS-1 the next state is DONE.
  - DONE: c <= {carry, accumulator}. done=1. The next state is IDLE, unconditionally.
- start is ignored in RUN and DONE. It is not queued. If start is held high, the block restarts from the first IDLE cycle.
- Widths: the limb index counter is clog2(N_LIMBS) bits, minimum 1. There is no overflow loss, because c is W+1 bits.
- N_LIMBS=1 is legal: RUN lasts one cycle.

## Timing

- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, c=0. Carry, index, operand and accumulator registers are all 0.
- Reset mid-operation:
  - the operation is abandoned and no done is produced.
  - c=0, and does not keep the previous result.
- Latency:
  - start is sampled at edge E0.
  - busy=1 from E0 to E(N_LIMBS).
  - done=1 and c valid from E(N_LIMBS) to E(N_LIMBS+1).
  - busy and done are never high together.
- Throughput:
  - one add per N_LIMBS+2 cycles with start held high.
  - the IDLE cycle after DONE is the earliest acceptance point.
- c changes only on the edge entering DONE, or on reset. Operand changes after E0 have no effect.
- busy and done are registered outputs (state decode of registered state). No combinational path from start.

## Test plan

Defaults LIMB_BITS=4, N_LIMBS=4 (W=16, c 17 bits).

1. Reset: assert rst asynchronously between edges -> busy=0, done=0, c=0x00000 immediately. Idle with start=0 for 10 cycles -> no change.
2. a=0x1234, b=0x4321, start pulsed at E0 -> busy high for E0..E4. done pulse E4..E5. c=0x05555. Then IDLE.
3. Full carry ripple: a=0xFFFF, b=0x0001 -> c=0x10000. Worst case: a=0xFFFF, b=0xFFFF -> c=0x1FFFE. Zero case: a=0, b=0 -> c=0, done still pulses.
4. start held high with operands changed every cycle during RUN/DONE:
   - done pulses every 6 cycles.
   - each result equals the sum of the operands present in the IDLE cycle that accepted it.
   - c stays stable between pulses.
5. Reset at limb 2 of a=0xABCD, b=0x1111 -> busy drops at once, c=0, no done. A following add of 0x8000+0x8000 -> c=0x10000 with normal latency (no stale carry).
6. Parameter sweep (LIMB_BITS, N_LIMBS) ∈ {(1,8), (8,1), (3,5)} with 200 random operand pairs each -> c=a+b, and done exactly N_LIMBS cycles after the accepting edge.

Source files
------------

// File: rtl/pos_add_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential multi-limb adder.
interface pos_add_seq_if #(
  parameter int LIMB_BITS = 4,
  parameter int N_LIMBS   = 4
);
  localparam int W = LIMB_BITS * N_LIMBS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W:0]   c;

  modport master (output start, a, b, input  busy, done, c);
  modport slave  (input  start, a, b, output busy, done, c);
endinterface

// File: rtl/pos_add_seq.sv
// Wide a+b computed one limb per cycle through a shared LIMB_BITS-wide adder slice,
// LSB limb first, with the inter-limb carry kept in a register.
module pos_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   s
);
  assign s = {1'b0, x} + {1'b0, y};
endmodule

module pos_add_seq #(
  parameter int LIMB_BITS = 4,
  parameter int N_LIMBS   = 4
) (
  input  logic          clk,
  input  logic          rst,
  pos_add_seq_if.slave  s
);
  localparam int W  = LIMB_BITS * N_LIMBS;
  localparam int IW = (N_LIMBS > 1) ? $clog2(N_LIMBS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_LIMBS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W:0]      c_q, c_d;

  logic [LIMB_BITS:0]   s1;
  logic [LIMB_BITS+1:0] s2;
  logic                 carry_nx;
  logic [W-1:0]         acc_shift;

  pos_add #(.W(LIMB_BITS)) u_slice1 (
    .x (a_q[LIMB_BITS-1:0]),
    .y (b_q[LIMB_BITS-1:0]),
    .s (s1)
  );

  pos_add #(.W(LIMB_BITS+1)) u_slice2 (
    .x (s1),
    .y ({{LIMB_BITS{1'b0}}, carry_q}),
    .s (s2)
  );

  // s2's top bit can never be set (max 2*(2^L-1)+1 < 2^(L+1)), so OR-ing it in is free
  assign carry_nx = |s2[LIMB_BITS+1:LIMB_BITS];

  if (N_LIMBS == 1) begin : g_one
    assign acc_shift = s2[LIMB_BITS-1:0];
  end else begin : g_multi
    assign acc_shift = {s2[LIMB_BITS-1:0], acc_q[W-1:LIMB_BITS]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: begin
        if (s.start) begin
          state_d = S_RUN;
          a_d     = s.a;
          b_d     = s.b;
          acc_d   = '0;
          idx_d   = '0;
          carry_d = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> LIMB_BITS;
        b_d     = b_q >> LIMB_BITS;
        acc_d   = acc_shift;
        carry_d = carry_nx;
        idx_d   = idx_q + 1'b1;
        // Result is loaded on the edge into DONE so c is valid together with done
        if (idx_q == LAST) begin
          state_d = S_DONE;
          idx_d   = '0;
          c_d     = {carry_nx, acc_shift};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      c_q     <= c_d;
    end
  end

  assign s.busy = (state_q == S_RUN);
  assign s.done = (state_q == S_DONE);
  assign s.c    = c_q;
endmodule

// File: tb/tb_pos_add_seq.sv
// Directed bench for pos_add_seq: default geometry plus three extra parameterisations.
module tb_pos_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pos_add_seq_if #(.LIMB_BITS(4), .N_LIMBS(4)) bus ();
  pos_add_seq_if #(.LIMB_BITS(1), .N_LIMBS(8)) i18 ();
  pos_add_seq_if #(.LIMB_BITS(8), .N_LIMBS(1)) i81 ();
  pos_add_seq_if #(.LIMB_BITS(3), .N_LIMBS(5)) i35 ();

  pos_add_seq #(.LIMB_BITS(4), .N_LIMBS(4)) dut     (.clk(clk), .rst(rst), .s(bus));
  pos_add_seq #(.LIMB_BITS(1), .N_LIMBS(8)) dut_18  (.clk(clk), .rst(rst), .s(i18));
  pos_add_seq #(.LIMB_BITS(8), .N_LIMBS(1)) dut_81  (.clk(clk), .rst(rst), .s(i81));
  pos_add_seq #(.LIMB_BITS(3), .N_LIMBS(5)) dut_35  (.clk(clk), .rst(rst), .s(i35));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One add from IDLE; operands are scrambled after acceptance to prove capture.
  task automatic do_add(input logic [15:0] a, input logic [15:0] b, input logic [16:0] e);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
    chk1("add_busy0", bus.busy, 1'b1);
    chk1("add_done0", bus.done, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk1("add_busy", bus.busy, k < 4);
      chk1("add_done", bus.done, k == 4);
    end
    chkv("add_c", 32'(bus.c), 32'(e));
    @(posedge clk); #1;
    chk1("add_done_end", bus.done, 1'b0);
    chk1("add_busy_end", bus.busy, 1'b0);
    chkv("add_c_hold", 32'(bus.c), 32'(e));
  endtask

  logic [15:0] ra, rb;
  logic [16:0] cur_c;
  logic [16:0] exp_q[$];
  logic [7:0]  a18, b18, a81, b81;
  logic [14:0] a35, b35;

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    i18.start = 1'b0; i18.a = '0; i18.b = '0;
    i81.start = 1'b0; i81.a = '0; i81.b = '0;
    i35.start = 1'b0; i35.a = '0; i35.b = '0;

    // Asynchronous reset between edges
    #12 rst = 1'b1;
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chkv("rst_c", 32'(bus.c), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_done", bus.done, 1'b0);
      chkv("idle_c", 32'(bus.c), 32'h0);
    end

    do_add(16'h1234, 16'h4321, 17'h05555);
    do_add(16'hFFFF, 16'h0001, 17'h10000);
    do_add(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    do_add(16'h0000, 16'h0000, 17'h00000);

    // start held high, operands changing every cycle; accepts every 6th edge
    cur_c = 17'h0;
    for (int k = 0; k < 30; k++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      bus.a = ra; bus.b = rb; bus.start = 1'b1;
      if (k % 6 == 0) exp_q.push_back({1'b0, ra} + {1'b0, rb});
      @(posedge clk); #1;
      chk1("held_busy", bus.busy, (k % 6) < 4);
      chk1("held_done", bus.done, (k % 6) == 4);
      if (k % 6 == 4) cur_c = exp_q.pop_front();
      chkv("held_c", 32'(bus.c), 32'(cur_c));
    end
    bus.start = 1'b0;

    // Reset while limb 2 is in flight
    bus.a = 16'hABCD; bus.b = 16'h1111; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk1("midrst_busy", bus.busy, 1'b0);
    chk1("midrst_done", bus.done, 1'b0);
    chkv("midrst_c", 32'(bus.c), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk1("postrst_done", bus.done, 1'b0);
      chkv("postrst_c", 32'(bus.c), 32'h0);
    end
    do_add(16'h8000, 16'h8000, 17'h10000);

    // Parameter sweep, all three geometries started on the same edge
    for (int it = 0; it < 200; it++) begin
      a18 = 8'($urandom);  b18 = 8'($urandom);
      a81 = 8'($urandom);  b81 = 8'($urandom);
      a35 = 15'($urandom); b35 = 15'($urandom);
      i18.a = a18; i18.b = b18; i18.start = 1'b1;
      i81.a = a81; i81.b = b81; i81.start = 1'b1;
      i35.a = a35; i35.b = b35; i35.start = 1'b1;
      @(posedge clk); #1;
      i18.start = 1'b0; i81.start = 1'b0; i35.start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        chk1("sw18_done", i18.done, k == 8);
        chk1("sw81_done", i81.done, k == 1);
        chk1("sw35_done", i35.done, k == 5);
        if (k == 8) chkv("sw18_c", 32'(i18.c), 32'({1'b0, a18} + {1'b0, b18}));
        if (k == 1) chkv("sw81_c", 32'(i81.c), 32'({1'b0, a81} + {1'b0, b81}));
        if (k == 5) chkv("sw35_c", 32'(i35.c), 32'({1'b0, a35} + {1'b0, b35}));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
